// File: rtl/life_engine.sv
// Game-of-Life engine for an 8x8 board: computes one generation row by row into a
// shadow register, then commits it in a single cycle.
module life_engine #(
    parameter int GEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [63:0]      pattern_mat,
    input  logic             step,
    input  logic             wrap_en,
    output logic [63:0]      board,
    output logic             busy,
    output logic             done,
    output logic [GEN_W-1:0] gen_count,
    output logic             alive,
    output logic             still
);

    typedef enum logic [1:0] {StIdle, StCalc, StCommit} state_t;

    state_t             state_q, state_d;
    logic [2:0]         row_q;
    logic               wrap_q;
    logic [63:0]        board_q, next_q, next_d;
    logic [GEN_W-1:0]   gen_q;
    logic               busy_q, done_q, still_q;
    logic               accept, calc_en, commit_en;
    logic [7:0]         row_new;

    // Bit 63-(8r+c) holds (r,c); for in-range r,c that index is ~{r,c}.
    function automatic logic cell_at(input logic [63:0] b, input int r, input int c,
                                     input logic wr);
        logic [5:0] idx;
        idx = ~{r[2:0], c[2:0]};
        if (!wr && (r < 0 || r > 7 || c < 0 || c > 7)) begin
            return 1'b0;
        end
        return b[idx];
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:   if (step) state_d = StCalc;
                StCalc:   if (row_q == 3'd7) state_d = StCommit;
                StCommit: state_d = StIdle;
                default:  state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        accept    = 1'b0;
        calc_en   = 1'b0;
        commit_en = 1'b0;
        unique case (state_q)
            StIdle:   accept    = step && !load;
            StCalc:   calc_en   = !load;
            StCommit: commit_en = !load;
            default:  ;
        endcase
    end

    // Neighbour count and B3/S23 rule for the row under evaluation.
    always_comb begin
        row_new = '0;
        for (int c = 0; c < 8; c++) begin
            logic [3:0] n;
            logic       self_live;
            n = '0;
            for (int dr = -1; dr <= 1; dr++) begin
                for (int dc = -1; dc <= 1; dc++) begin
                    if (dr != 0 || dc != 0) begin
                        n = n + {3'b000, cell_at(board_q, int'(row_q) + dr, c + dc, wrap_q)};
                    end
                end
            end
            self_live = cell_at(board_q, int'(row_q), c, 1'b0);
            row_new[3'(7 - c)] = (n == 4'd3) || (self_live && n == 4'd2);
        end
    end

    // Rows arrive top-first, so after eight shifts row 0 sits in the MSB byte.
    assign next_d = {next_q[55:0], row_new};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            board_q <= '0;
            next_q  <= '0;
            gen_q   <= '0;
            row_q   <= '0;
            wrap_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            still_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (load) begin
                board_q <= pattern_mat;
                gen_q   <= '0;
                still_q <= 1'b0;
                busy_q  <= 1'b0;
            end else if (accept) begin
                wrap_q <= wrap_en;
                row_q  <= '0;
                busy_q <= 1'b1;
            end else if (calc_en) begin
                next_q <= next_d;
                row_q  <= row_q + 3'd1;
            end else if (commit_en) begin
                board_q <= next_q;
                gen_q   <= gen_q + GEN_W'(1);
                still_q <= (next_q == board_q);
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
            end
        end
    end

    assign board     = board_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign gen_count = gen_q;
    assign still     = still_q;
    assign alive     = |board_q;

endmodule

// File: tb/tb_life_engine.sv
// Directed bench for life_engine: known patterns, commit timing, abort and reset behaviour.
module tb_life_engine;

    logic        clk, rst, load, step, wrap_en;
    logic [63:0] pattern_mat, board;
    logic        busy, done, alive, still;
    logic [15:0] gen_count;

    int checks = 0;
    int errors = 0;
    logic saw;

    localparam logic [63:0] Blinker  = 64'h00000038_00000000;
    localparam logic [63:0] BlinkerV = 64'h00001010_10000000;
    localparam logic [63:0] Block    = 64'hC0C0_0000_0000_0000;
    localparam logic [63:0] Single   = 64'h8000_0000_0000_0000;
    localparam logic [63:0] Corner   = 64'hE000_0000_0000_0000;

    life_engine #(.GEN_W(16)) dut (
        .clk(clk), .rst(rst), .load(load), .pattern_mat(pattern_mat), .step(step),
        .wrap_en(wrap_en), .board(board), .busy(busy), .done(done),
        .gen_count(gen_count), .alive(alive), .still(still)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_load(input logic [63:0] pat, input string tag);
        pattern_mat = pat;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        chk({tag, "_board"}, board, pat);
        chk({tag, "_gen"}, 64'(gen_count), 64'd0);
        chk({tag, "_still"}, 64'(still), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
    endtask

    // Accept edge, then 8 calc edges, then the commit edge; wrap_en flips while busy.
    task automatic do_step(input logic wrap, input logic [63:0] exp_board,
                           input logic [15:0] exp_gen, input logic exp_still, input string tag);
        logic seen;
        wrap_en = wrap;
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        wrap_en = ~wrap;
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen |= done;
        end
        chk({tag, "_done_early"}, 64'(seen), 64'd0);
        @(negedge clk);
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_busy_off"}, 64'(busy), 64'd0);
        chk({tag, "_board"}, board, exp_board);
        chk({tag, "_gen"}, 64'(gen_count), 64'(exp_gen));
        chk({tag, "_still"}, 64'(still), 64'(exp_still));
        chk({tag, "_alive"}, 64'(alive), 64'(|exp_board));
        @(negedge clk);
        chk({tag, "_done_once"}, 64'(done), 64'd0);
    endtask

    task automatic quiet(input int n, input string tag);
        logic seen;
        seen = 1'b0;
        repeat (n) begin
            @(negedge clk);
            seen |= done;
        end
        chk({tag, "_no_done"}, 64'(seen), 64'd0);
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; step = 1'b0; wrap_en = 1'b0; pattern_mat = '0;
        #3;
        chk("rst_board", board, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_gen", 64'(gen_count), 64'd0);
        chk("rst_alive", 64'(alive), 64'd0);
        chk("rst_still", 64'(still), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Blinker oscillates.
        do_load(Blinker, "ld_blink");
        do_step(1'b0, BlinkerV, 16'd1, 1'b0, "blink1");
        do_step(1'b0, Blinker, 16'd2, 1'b0, "blink2");

        // Still life and lone cell.
        do_load(Block, "ld_block");
        do_step(1'b0, Block, 16'd1, 1'b1, "block");
        do_load(Single, "ld_single");
        do_step(1'b0, 64'd0, 16'd1, 1'b0, "single");

        // Edge handling.
        do_load(Corner, "ld_corner_w");
        do_step(1'b1, 64'h4040_0000_0000_0040, 16'd1, 1'b0, "wrap1");
        do_load(Corner, "ld_corner_n");
        do_step(1'b0, 64'h4040_0000_0000_0000, 16'd1, 1'b0, "wrap0");

        // Load at CALC cycle 4 aborts the generation.
        do_load(Blinker, "ld_abort");
        do_step(1'b0, BlinkerV, 16'd1, 1'b0, "pre_abort");
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        repeat (3) @(negedge clk);
        pattern_mat = Block;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        chk("abort_board", board, Block);
        chk("abort_gen", 64'(gen_count), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        quiet(12, "abort");
        chk("abort_board_hold", board, Block);

        // Step pulses while busy are dropped.
        do_load(Corner, "ld_extra");
        wrap_en = 1'b0;
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        @(negedge clk);
        @(negedge clk); step = 1'b1;
        @(negedge clk); step = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); step = 1'b1;
        @(negedge clk); step = 1'b0;
        @(negedge clk); step = 1'b1;
        @(negedge clk); step = 1'b0;
        chk("extra_done", 64'(done), 64'd1);
        chk("extra_board", board, 64'h4040_0000_0000_0000);
        chk("extra_gen", 64'(gen_count), 64'd1);
        quiet(12, "extra");
        chk("extra_gen_hold", 64'(gen_count), 64'd1);
        chk("extra_busy", 64'(busy), 64'd0);

        // Load wins over a simultaneous step.
        pattern_mat = Blinker;
        load = 1'b1;
        step = 1'b1;
        @(negedge clk);
        load = 1'b0;
        step = 1'b0;
        chk("ldstep_board", board, Blinker);
        chk("ldstep_busy", 64'(busy), 64'd0);
        quiet(12, "ldstep");
        chk("ldstep_board_hold", board, Blinker);

        // Asynchronous reset between edges mid-CALC.
        do_load(Block, "ld_rst");
        do_step(1'b0, Block, 16'd1, 1'b1, "pre_rst");
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_board", board, 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_gen", 64'(gen_count), 64'd0);
        chk("arst_still", 64'(still), 64'd0);
        chk("arst_alive", 64'(alive), 64'd0);
        #1 rst = 1'b0;
        quiet(12, "arst");
        chk("arst_board_hold", board, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/life_engine.md
LIFE_ENGINE -- requirements
Module: life_engine

Interface
REQ-001 SHALL have parameter GEN_W, default 16, generation counter width.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port load  input  1  pulse that copies pattern_mat into the board.
REQ-005 SHALL have port pattern_mat  input  64  seed board; bit 63-(8*r+c) = row r, col c; row 0 is the top (MSB byte), col 0 is the MSB of each byte.
REQ-006 SHALL have port step  input  1  pulse requesting one generation.
REQ-007 SHALL have port wrap_en  input  1  1 = toroidal edges, 0 = cells outside the 8x8 board are dead.
REQ-008 SHALL have port board  output  64  current generation, same bit mapping as pattern_mat.
REQ-009 SHALL have port busy  output  1  high while a generation is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse when a generation commits.
REQ-011 SHALL have port gen_count  output  GEN_W  number of generations since the last load.
REQ-012 SHALL have port alive  output  1  combinational OR of all board bits.
REQ-013 SHALL have port still  output  1  last committed generation equals its predecessor.

Function
REQ-014 SHALL implement FSM states IDLE, CALC and COMMIT.
REQ-015 SHALL, in IDLE with load=1, set board<=pattern_mat, gen_count<=0 and still<=0; no done pulse.
REQ-016 SHALL, in IDLE with step=1 and load=0, latch wrap_en, clear the row counter and enter CALC; busy=1 from the next cycle.
REQ-017 SHALL, in CALC, compute one row per cycle (rows 0..7, 8 cycles) into a shadow next register, reading only the unchanged board.
REQ-018 SHALL apply rule B3/S23: dead cell with exactly 3 live neighbours becomes live; live cell with 2 or 3 survives; all other cells become dead.
REQ-019 SHALL compute neighbours with row/col indices modulo 8 when latched wrap_en=1; when latched wrap_en=0, out-of-range neighbours count as 0.
REQ-020 SHALL enter COMMIT after row 7.
REQ-021 SHALL, in COMMIT, perform: board<=next; gen_count<=gen_count+1 (wraps modulo 2^GEN_W); still<=(next==board); done=1 for exactly one cycle; busy=0; return to IDLE.
REQ-022 SHALL update board 9 clock edges after the edge that accepts step; done is high in the cycle following that commit edge.
REQ-023 SHALL ignore step while busy; step is not queued.
REQ-024 SHALL give load priority in every state: in CALC or COMMIT, load aborts the generation, loads pattern_mat, clears gen_count and still, returns to IDLE, and produces no done pulse.
REQ-025 SHALL, when load and step are both high in IDLE, perform the load and drop the step.
REQ-026 SHALL ignore wrap_en changes while busy.

Reset
REQ-027 SHALL, on rst=1 regardless of clk, force state=IDLE, board=0, next=0, gen_count=0, busy=0, done=0 and still=0; alive is then 0.
REQ-028 SHALL abort any in-flight generation on reset assertion mid-CALC, with no later done pulse.
REQ-029 SHALL accept load/step on the first rising edge after rst deasserts.

Verification
REQ-030 SHALL cover: load 64'h00000038_00000000, wrap_en=0, step -> after 9 edges board=64'h00001010_10000000, done pulses once, gen_count=1; second step -> 64'h00000038_00000000, gen_count=2.
REQ-031 SHALL cover: load 64'hC0C0_0000_0000_0000, step -> board unchanged, still=1, alive=1.
REQ-032 SHALL cover: load 64'h8000_0000_0000_0000, step -> board=0, alive=0, still=0.
REQ-033 SHALL cover: load 64'hE000_0000_0000_0000, step with wrap_en=1 -> 64'h4040_0000_0000_0040; reload, step with wrap_en=0 -> 64'h4040_0000_0000_0000.
REQ-034 SHALL cover: step accepted, then load at CALC cycle 4 -> board=new pattern_mat, gen_count=0, no done; extra step pulses during busy leave gen_count +1 only.
REQ-035 SHALL cover: rst asserted mid-CALC, asynchronously between clock edges -> outputs 0 immediately; no done after deassert.
